// File: rtl/sram_axi_pkg.sv
// Shared definitions for the sram_axi_slave memory responder.
// n_pmem_read/n_pmem_write are provided by a behavioural word store with
// call counters standing in for the simulated physical memory.
package sram_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

  // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // 33-bit compare so base+size cannot wrap past 2^32
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] size);
    logic [32:0] a, lo, hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = {1'b0, base} + {1'b0, size};
    return (a >= lo) && (a < hi);
  endfunction

  // Random latency 0 is promoted to 1; counter holds latency-1
  function automatic logic [3:0] lat_to_cnt(input logic [3:0] lat);
    return (lat == 4'd0) ? 4'd0 : lat - 4'd1;
  endfunction

  // Sparse word store standing in for the simulator's physical memory
  logic [31:0] pmem [logic [29:0]];
  int unsigned pmem_rd_calls = 0;
  int unsigned pmem_wr_calls = 0;

  function automatic logic [31:0] n_pmem_read(input logic [31:0] raddr);
    pmem_rd_calls++;
    if (pmem.exists(raddr[31:2])) return pmem[raddr[31:2]];
    return 32'h0;
  endfunction

  function automatic void n_pmem_write(input logic [31:0] waddr,
                                       input logic [31:0] wdata,
                                       input logic [7:0]  wmask);
    logic [31:0] word;
    pmem_wr_calls++;
    word = pmem.exists(waddr[31:2]) ? pmem[waddr[31:2]] : 32'h0;
    for (int b = 0; b < 4; b++)
      if (wmask[b]) word[8*b +: 8] = wdata[8*b +: 8];
    pmem[waddr[31:2]] = word;
  endfunction

endpackage

// File: rtl/sram_axi_slave_delay_lfsr.sv
// Free-running 16-bit Fibonacci LFSR supplying random latencies.
// Only instantiated when SRAM_RAND_DELAY_EN is defined.
module delay_lfsr
  import sram_axi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] out
);

  logic [15:0] state;

  // Shift left every cycle, feedback is the XOR of the tapped bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LFSR_SEED;
    else      state <= {state[14:0], ^(state & LFSR_TAPS)};
  end

  assign out = state[3:0];

endmodule

// File: rtl/sram_axi_slave.sv
// AXI4-Lite memory responder for the NPC core arbiter.
// One read and one write outstanding, independent channels, latency
// set by RD_LAT/WR_LAT or, with SRAM_RAND_DELAY_EN defined, by an LFSR.
// Reads commit before writes in the same cycle so a colliding read sees
// pre-write memory.
module sram_axi_slave
  import sram_axi_pkg::*;
#(
  parameter int          RD_LAT   = 1,
  parameter int          WR_LAT   = 1,
  parameter logic [31:0] MEM_BASE = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0800_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  rd_state_t   rd_state;
  wr_state_t   wr_state;
  logic [3:0]  rd_cnt, wr_cnt;
  logic [3:0]  rd_load, wr_load;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic        aw_held, w_held;
  logic        ar_hs, aw_hs, w_hs;
  logic        aw_have, w_have;

  // Only the low four strobes address a 32-bit word
  logic unused_strb;
  assign unused_strb = ^wstrb[7:4];

`ifdef SRAM_RAND_DELAY_EN
  logic [3:0] lfsr_out;
  logic [7:0] unused_lat;

  delay_lfsr u_delay_lfsr (
    .clk (clk),
    .rst (rst),
    .out (lfsr_out)
  );

  assign rd_load    = lat_to_cnt(lfsr_out);
  assign wr_load    = lat_to_cnt(lfsr_out);
  assign unused_lat = {4'(RD_LAT), 4'(WR_LAT)};
`else
  assign rd_load = 4'(RD_LAT - 1);
  assign wr_load = 4'(WR_LAT - 1);
`endif

  assign ar_hs   = arvalid && arready;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid  && wready;
  // A payload counts as present from the cycle its handshake happens
  assign aw_have = aw_held || aw_hs;
  assign w_have  = w_held  || w_hs;

  // Both channel FSMs share one process so read commit precedes write commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= R_IDLE;
      rd_cnt   <= 4'd0;
      rd_addr  <= 32'h0;
      arready  <= 1'b1;
      rvalid   <= 1'b0;
      rdata    <= 32'h0;
      rresp    <= RESP_OKAY;
      wr_state <= W_IDLE;
      wr_cnt   <= 4'd0;
      wr_addr  <= 32'h0;
      wr_data  <= 32'h0;
      wr_strb  <= 4'h0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awready  <= 1'b1;
      wready   <= 1'b1;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
    end else begin
      // ---- read channel ----
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rd_addr  <= araddr;
            rd_cnt   <= rd_load;
            arready  <= 1'b0;
            rd_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rd_cnt == 4'd0) begin
            if (in_range(rd_addr, MEM_BASE, MEM_SIZE)) begin
              rdata <= n_pmem_read(rd_addr);
              rresp <= RESP_OKAY;
            end else begin
              rdata <= 32'h0;
              rresp <= RESP_SLVERR;
            end
            rvalid   <= 1'b1;
            rd_state <= R_RESP;
          end else begin
            rd_cnt <= rd_cnt - 4'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid   <= 1'b0;
            arready  <= 1'b1;
            rd_state <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase

      // ---- write channel ----
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            wr_addr <= awaddr;
            awready <= 1'b0;
            aw_held <= 1'b1;
          end
          if (w_hs) begin
            wr_data <= wdata;
            wr_strb <= wstrb[3:0];
            wready  <= 1'b0;
            w_held  <= 1'b1;
          end
          if (aw_have && w_have) begin
            wr_cnt   <= wr_load;
            wr_state <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (wr_cnt == 4'd0) begin
            if (in_range(wr_addr, MEM_BASE, MEM_SIZE)) begin
              n_pmem_write(wr_addr, wr_data, {4'b0, wr_strb});
              bresp <= RESP_OKAY;
            end else begin
              bresp <= RESP_SLVERR;
            end
            bvalid   <= 1'b1;
            wr_state <= W_RESP;
          end else begin
            wr_cnt <= wr_cnt - 4'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wready   <= 1'b1;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_slave.sv
// Directed bench for sram_axi_slave with default latencies (1/1).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_sram_axi_slave;
  import sram_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [7:0]  wstrb = '0;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  int cmp_cnt = 0;
  int mis_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      mis_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  sram_axi_slave dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] r, output logic to);
    int n = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (!arready && n < 40) begin tick(); n++; end
    tick(); arvalid = 1'b0;
    while (!rvalid && n < 40) begin tick(); n++; end
    d = rdata; r = rresp; to = (n >= 40);
    tick();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [7:0] s, output logic [1:0] r,
                          output logic to);
    int n = 0;
    logic ah, wh;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while ((awvalid || wvalid) && n < 40) begin
      ah = awvalid && awready;
      wh = wvalid && wready;
      tick(); n++;
      if (ah) awvalid = 1'b0;
      if (wh) wvalid = 1'b0;
    end
    while (!bvalid && n < 40) begin tick(); n++; end
    r = bresp; to = (n >= 40);
    tick();
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic        to;
    int unsigned calls;

    tick(); tick();
    chk("rst_arready", arready, 1'b1);
    chk("rst_awready", awready, 1'b1);
    chk("rst_wready", wready, 1'b1);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_bresp", bresp, 2'b00);

    pmem[30'h2000_0000] = 32'hDEAD_BEEF;
    pmem[30'h2000_0004] = 32'hAABB_CCDD;
    pmem[30'h2000_0008] = 32'h0000_0001;
    pmem[30'h2000_000C] = 32'h0000_0055;
    rst = 1'b1;
    tick();

    araddr = 32'h8000_0000; arvalid = 1'b1; rready = 1'b1;
    tick(); arvalid = 1'b0;
    chk("rd1_arready_drop", arready, 1'b0);
    chk("rd1_rvalid_early", rvalid, 1'b0);
    tick();
    chk("rd1_rvalid", rvalid, 1'b1);
    chk("rd1_rdata", rdata, 32'hDEAD_BEEF);
    chk("rd1_rresp", rresp, 2'b00);
    tick();
    chk("rd1_rvalid_drop", rvalid, 1'b0);
    chk("rd1_arready_back", arready, 1'b1);

    wdata = 32'h1234_5678; wstrb = 8'hF3; wvalid = 1'b1; bready = 1'b1;
    tick(); wvalid = 1'b0;
    chk("wr1_wready_drop", wready, 1'b0);
    chk("wr1_awready_hold", awready, 1'b1);
    awaddr = 32'h8000_0010; awvalid = 1'b1;
    tick(); awvalid = 1'b0;
    chk("wr1_awready_drop", awready, 1'b0);
    chk("wr1_bvalid_early", bvalid, 1'b0);
    tick();
    chk("wr1_bvalid", bvalid, 1'b1);
    chk("wr1_bresp", bresp, 2'b00);
    tick();
    chk("wr1_bvalid_drop", bvalid, 1'b0);
    chk("wr1_awready_back", awready, 1'b1);
    chk("wr1_wready_back", wready, 1'b1);
    do_read(32'h8000_0010, d, r, to);
    chk("wr1_readback", d, 32'hAABB_5678);
    chk("wr1_readback_to", to, 1'b0);

    calls = pmem_rd_calls;
    do_read(32'h0000_0004, d, r, to);
    chk("oor_rd_to", to, 1'b0);
    chk("oor_rd_rresp", r, 2'b10);
    chk("oor_rd_rdata", d, 32'h0);
    chk("oor_rd_nocall", pmem_rd_calls, calls);
    do_read(32'h87FF_FFFC, d, r, to);
    chk("top_word_to", to, 1'b0);
    chk("top_word_rresp", r, 2'b00);
    do_read(32'h8800_0000, d, r, to);
    chk("end_addr_to", to, 1'b0);
    chk("end_addr_rresp", r, 2'b10);
    calls = pmem_wr_calls;
    do_write(32'h9000_0000, 32'hCAFE_F00D, 8'h0F, r, to);
    chk("oor_wr_to", to, 1'b0);
    chk("oor_wr_bresp", r, 2'b10);
    chk("oor_wr_nocall", pmem_wr_calls, calls);
    chk("oor_wr_nomem", pmem.exists(30'h2400_0000), 0);
    do_write(32'h8000_0010, 32'hFFFF_FFFF, 8'h00, r, to);
    chk("nostrb_to", to, 1'b0);
    chk("nostrb_bresp", r, 2'b00);
    chk("nostrb_mem", pmem[30'h2000_0004], 32'hAABB_5678);

    rready = 1'b0; araddr = 32'h8000_0000; arvalid = 1'b1;
    tick();
    araddr = 32'h8000_0010;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid", rvalid, 1'b1);
      chk("bp_rdata", rdata, 32'hDEAD_BEEF);
      chk("bp_arready", arready, 1'b0);
      tick();
    end
    rready = 1'b1;
    tick();
    chk("bp_rvalid_drop", rvalid, 1'b0);
    chk("bp_arready_back", arready, 1'b1);
    tick(); arvalid = 1'b0;
    chk("bp_ar2_taken", arready, 1'b0);
    tick();
    chk("bp_ar2_rvalid", rvalid, 1'b1);
    chk("bp_ar2_rdata", rdata, 32'hAABB_5678);
    tick();

    araddr = 32'h8000_0020; awaddr = 32'h8000_0020;
    wdata = 32'h2; wstrb = 8'h0F;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1; rready = 1'b1; bready = 1'b1;
    tick(); arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("coll_rvalid", rvalid, 1'b1);
    chk("coll_bvalid", bvalid, 1'b1);
    chk("coll_rdata_old", rdata, 32'h1);
    tick();
    do_read(32'h8000_0020, d, r, to);
    chk("coll_rd_to", to, 1'b0);
    chk("coll_rdata_new", d, 32'h2);

    calls = pmem_wr_calls;
    awaddr = 32'h8000_0030; wdata = 32'h99; wstrb = 8'h0F;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick(); awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_awready", awready, 1'b1);
    chk("mid_rst_wready", wready, 1'b1);
    chk("mid_rst_arready", arready, 1'b1);
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_no_bvalid", bvalid, 1'b0);
    end
    chk("mid_rst_mem", pmem[30'h2000_000C], 32'h55);
    chk("mid_rst_nocall", pmem_wr_calls, calls);
    chk("mid_rst_awready_after", awready, 1'b1);
    chk("mid_rst_wready_after", wready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
